// File: rtl/sms_cart_pkg.sv
// Shared constants and state type for the SMS cartridge mapper.
// Register addresses, slot boundaries and ctrl bit positions are used by both the decoder and the top.
package sms_cart_pkg;

  localparam logic [15:0] ADDR_CTRL  = 16'hFFFC;
  localparam logic [15:0] ADDR_BANK0 = 16'hFFFD;
  localparam logic [15:0] ADDR_BANK1 = 16'hFFFE;
  localparam logic [15:0] ADDR_BANK2 = 16'hFFFF;

  localparam logic [15:0] FIXED_END  = 16'h0400;
  localparam logic [15:0] SLOT1_BASE = 16'h4000;
  localparam logic [15:0] SLOT2_BASE = 16'h8000;
  localparam logic [15:0] CART_END   = 16'hC000;

  localparam int CTRL_RAM_EN   = 3;
  localparam int CTRL_RAM_PAGE = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SRAMRD = 2'd2,
    HOLD   = 2'd3
  } rd_state_t;

endpackage

// File: rtl/sms_cart_decode.sv
// Combinational Z80 address decode: selects ROM bank or cart RAM page for 0000-BFFF.
// Addresses at C000 and above decode to neither region.
module sms_cart_decode
  import sms_cart_pkg::*;
#(
  parameter int ROM_AW  = 22,
  parameter int SRAM_AW = 15
) (
  input  logic [15:0]         address,
  input  logic                ram_en,
  input  logic                ram_page,
  input  logic [ROM_AW-15:0]  bank0,
  input  logic [ROM_AW-15:0]  bank1,
  input  logic [ROM_AW-15:0]  bank2,
  input  logic [ROM_AW-15:0]  rom_bank_mask,
  output logic                is_rom,
  output logic                is_sram,
  output logic [ROM_AW-1:0]   rom_addr,
  output logic [SRAM_AW-1:0]  sram_addr
);

  logic [ROM_AW-15:0] bank;

  always_comb begin
    bank    = '0;
    is_rom  = 1'b0;
    is_sram = 1'b0;
    if (address < FIXED_END) begin
      is_rom = 1'b1;
    end else if (address < SLOT1_BASE) begin
      bank   = bank0;
      is_rom = 1'b1;
    end else if (address < SLOT2_BASE) begin
      bank   = bank1;
      is_rom = 1'b1;
    end else if (address < CART_END) begin
      if (ram_en) begin
        is_sram = 1'b1;
      end else begin
        bank   = bank2;
        is_rom = 1'b1;
      end
    end
  end

  assign rom_addr  = {bank & rom_bank_mask, address[13:0]};
  assign sram_addr = SRAM_AW'({ram_page, address[13:0]});

endmodule

// File: rtl/sms_cart_mapper.sv
// SMS cartridge responder: 315-5235 style paging registers, ROM fetch via req/ack, battery RAM.
// Strobes are edge-detected against one-cycle delayed copies.
//
//   state  | meaning
//   IDLE   | waiting for a read event
//   FETCH  | rom_req outstanding, waiting for rom_ack
//   SRAMRD | cart RAM address presented, waiting out the read latency
//   HOLD   | cart_data valid, driven while cart_cs & cart_oe stay high
module sms_cart_mapper
  import sms_cart_pkg::*;
#(
  parameter int ROM_AW  = 22,
  parameter int SRAM_AW = 15
) (
  input  logic                MCLK,
  input  logic                ext_reset,
  input  logic [15:0]         cart_address,
  input  logic                cart_cs,
  input  logic                cart_oe,
  input  logic                cart_wr,
  input  logic [7:0]          cart_data_wr,
  output logic [7:0]          cart_data,
  output logic                cart_data_en,
  input  logic [ROM_AW-15:0]  rom_bank_mask,
  output logic [ROM_AW-1:0]   rom_addr,
  output logic                rom_req,
  input  logic                rom_ack,
  input  logic [7:0]          rom_q,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [7:0]          sram_d,
  output logic                sram_we,
  input  logic [7:0]          sram_q
);

  localparam int BW = ROM_AW - 14;

  rd_state_t state, state_nxt;
  logic [7:0]    ctrl;
  logic [BW-1:0] bank0, bank1, bank2;
  logic          wr_q, rd_q;
  logic          sram_wait_cnt;

  logic strobe, wr_evt, rd_evt, sram_wr;
  logic ld_rom, ld_sram, cap_rom, cap_sram, en_nxt;
  logic dec_rom, dec_sram;
  logic [ROM_AW-1:0]  dec_rom_addr;
  logic [SRAM_AW-1:0] dec_sram_addr;
  logic ctrl_unused;

  assign strobe  = cart_cs & cart_oe;
  assign wr_evt  = cart_wr & ~wr_q;
  assign rd_evt  = strobe & ~rd_q;
  assign sram_wr = wr_evt & cart_cs & dec_sram;
  assign ctrl_unused = ^{ctrl[7:4], ctrl[1:0]};

  sms_cart_decode #(.ROM_AW(ROM_AW), .SRAM_AW(SRAM_AW)) u_decode (
    .address       (cart_address),
    .ram_en        (ctrl[CTRL_RAM_EN]),
    .ram_page      (ctrl[CTRL_RAM_PAGE]),
    .bank0         (bank0),
    .bank1         (bank1),
    .bank2         (bank2),
    .rom_bank_mask (rom_bank_mask),
    .is_rom        (dec_rom),
    .is_sram       (dec_sram),
    .rom_addr      (dec_rom_addr),
    .sram_addr     (dec_sram_addr)
  );

  always_ff @(posedge MCLK) begin
    if (ext_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_rom    = 1'b0;
    ld_sram   = 1'b0;
    cap_rom   = 1'b0;
    cap_sram  = 1'b0;
    en_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_evt && dec_rom) begin
          state_nxt = FETCH;
          ld_rom    = 1'b1;
        end else if (rd_evt && dec_sram) begin
          state_nxt = SRAMRD;
          ld_sram   = 1'b1;
        end
      end
      FETCH: begin
        if (rom_ack) begin
          cap_rom   = 1'b1;
          en_nxt    = strobe;
          state_nxt = strobe ? HOLD : IDLE;
        end
      end
      SRAMRD: begin
        if (sram_wait_cnt == 1'b0) begin
          cap_sram  = 1'b1;
          en_nxt    = strobe;
          state_nxt = strobe ? HOLD : IDLE;
        end
      end
      HOLD: begin
        en_nxt = strobe;
        if (!strobe) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      ctrl          <= 8'h00;
      bank0         <= BW'(0);
      bank1         <= BW'(1);
      bank2         <= BW'(2);
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      cart_data     <= 8'h00;
      cart_data_en  <= 1'b0;
      rom_addr      <= '0;
      rom_req       <= 1'b0;
      sram_addr     <= '0;
      sram_d        <= 8'h00;
      sram_we       <= 1'b0;
      sram_wait_cnt <= 1'b0;
    end else begin
      wr_q         <= cart_wr;
      rd_q         <= strobe;
      cart_data_en <= en_nxt;
      sram_we      <= sram_wr;

      // register snoop ignores cart_cs; the paging registers sit above the cart window
      if (wr_evt) begin
        case (cart_address)
          ADDR_CTRL:  ctrl  <= cart_data_wr;
          ADDR_BANK0: bank0 <= BW'(cart_data_wr);
          ADDR_BANK1: bank1 <= BW'(cart_data_wr);
          ADDR_BANK2: bank2 <= BW'(cart_data_wr);
          default: ;
        endcase
      end

      if (ld_rom) begin
        rom_addr <= dec_rom_addr;
        rom_req  <= 1'b1;
      end else if (cap_rom) begin
        rom_req  <= 1'b0;
      end

      if (ld_sram) begin
        sram_addr     <= dec_sram_addr;
        sram_wait_cnt <= 1'b1;
      end else if (sram_wr) begin
        sram_addr <= dec_sram_addr;
        sram_d    <= cart_data_wr;
      end else if (state == SRAMRD && sram_wait_cnt != 1'b0) begin
        sram_wait_cnt <= sram_wait_cnt - 1'b1;
      end

      if (cap_rom)       cart_data <= rom_q;
      else if (cap_sram) cart_data <= sram_q;
    end
  end

endmodule

// File: tb/tb_sms_cart_mapper.sv
// Self-checking bench for sms_cart_mapper: directed scenarios plus randomized reads
// against an arithmetic model of the paging registers and cart RAM.
module tb_sms_cart_mapper;

  localparam int ROM_AW  = 22;
  localparam int SRAM_AW = 15;

  logic        MCLK;
  logic        ext_reset;
  logic [15:0] cart_address;
  logic        cart_cs, cart_oe, cart_wr;
  logic [7:0]  cart_data_wr;
  logic [7:0]  cart_data;
  logic        cart_data_en;
  logic [7:0]  rom_bank_mask;
  logic [ROM_AW-1:0]  rom_addr;
  logic        rom_req, rom_ack;
  logic [7:0]  rom_q;
  logic [SRAM_AW-1:0] sram_addr;
  logic [7:0]  sram_d;
  logic        sram_we;
  logic [7:0]  sram_q;

  int checks = 0;
  int passed = 0;

  logic [7:0] ctrl_m;
  logic [7:0] bank_m [3];
  logic [7:0] mask_m;
  logic [7:0] sram_m [0:32767];
  logic [7:0] mem    [0:32767];

  sms_cart_mapper #(.ROM_AW(ROM_AW), .SRAM_AW(SRAM_AW)) dut (
    .MCLK(MCLK), .ext_reset(ext_reset), .cart_address(cart_address),
    .cart_cs(cart_cs), .cart_oe(cart_oe), .cart_wr(cart_wr), .cart_data_wr(cart_data_wr),
    .cart_data(cart_data), .cart_data_en(cart_data_en), .rom_bank_mask(rom_bank_mask),
    .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_q(rom_q),
    .sram_addr(sram_addr), .sram_d(sram_d), .sram_we(sram_we), .sram_q(sram_q)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // cart RAM stub with one-cycle synchronous read
  always @(posedge MCLK) begin
    if (sram_we) mem[sram_addr] <= sram_d;
    sram_q <= mem[sram_addr];
  end

  function automatic logic [21:0] model_rom(input logic [15:0] a);
    int bank;
    if (a < 16'h0400) bank = 0;
    else bank = int'(bank_m[int'(a) / 16384]);
    bank = bank & int'(mask_m);
    return 22'(bank * 16384 + int'(a) % 16384);
  endfunction

  function automatic logic model_is_sram(input logic [15:0] a);
    return (a >= 16'h8000) && (a < 16'hC000) && ctrl_m[3];
  endfunction

  function automatic logic [14:0] model_sram_addr(input logic [15:0] a);
    return 15'(int'(ctrl_m[2]) * 16384 + int'(a) % 16384);
  endfunction

  task automatic step();
    @(negedge MCLK);
  endtask

  task automatic model_reset();
    ctrl_m = 8'h00;
    bank_m[0] = 8'd0; bank_m[1] = 8'd1; bank_m[2] = 8'd2;
  endtask

  task automatic apply_reset();
    ext_reset = 1'b1;
    cart_cs = 0; cart_oe = 0; cart_wr = 0; rom_ack = 0;
    step(); step();
    ext_reset = 1'b0;
    model_reset();
    step();
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    cart_address = a; cart_data_wr = d; cart_wr = 1'b1; cart_cs = (a < 16'hC000);
    if (model_is_sram(a)) sram_m[model_sram_addr(a)] = d;
    case (a)
      16'hFFFC: ctrl_m = d;
      16'hFFFD: bank_m[0] = d;
      16'hFFFE: bank_m[1] = d;
      16'hFFFF: bank_m[2] = d;
      default: ;
    endcase
    step(); step();
    cart_wr = 1'b0; cart_cs = 1'b0;
    step();
  endtask

  // Runs one read cycle; acks the ROM request ack_dly cycles after it appears.
  task automatic do_read(input logic [15:0] a, input logic [7:0] q, input int ack_dly,
                         output logic was_rom, output logic [21:0] ra, output logic [7:0] d,
                         output logic en, output int lat, output logic en_off);
    int req_cyc;
    logic acked;
    req_cyc = 0; acked = 0; was_rom = 0; ra = '0; lat = 0;
    cart_address = a; cart_cs = 1'b1; cart_oe = 1'b1;
    while (lat < 40) begin
      step();
      lat++;
      rom_ack = 1'b0;
      if (cart_data_en) break;
      if (rom_req && !acked) begin
        if (!was_rom) begin was_rom = 1'b1; ra = rom_addr; end
        if (req_cyc == ack_dly) begin rom_ack = 1'b1; rom_q = q; acked = 1'b1; end
        req_cyc++;
      end
    end
    rom_ack = 1'b0;
    d = cart_data; en = cart_data_en;
    cart_oe = 1'b0; cart_cs = 1'b0;
    step();
    en_off = cart_data_en;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (cart_data_en !== 1'b0) $display("FAIL reset_en: got %b want 0", cart_data_en); else passed++;
    checks++; if (rom_req !== 1'b0) $display("FAIL reset_req: got %b want 0", rom_req); else passed++;
    checks++; if (sram_we !== 1'b0) $display("FAIL reset_we: got %b want 0", sram_we); else passed++;
    checks++; if (cart_data !== 8'h00) $display("FAIL reset_data: got %h want 00", cart_data); else passed++;
  endtask

  task automatic test_default_banks();
    logic wr; logic [21:0] ra; logic [7:0] d; logic en, off; int lat;
    do_read(16'h4123, 8'h5A, 2, wr, ra, d, en, lat, off);
    checks++; if (ra !== 22'h004123) $display("FAIL def_addr: got %h want 004123", ra); else passed++;
    checks++; if (d !== 8'h5A || en !== 1'b1) $display("FAIL def_data: got %h/%b want 5a/1", d, en); else passed++;
    checks++; if (lat !== 4) $display("FAIL def_latency: got %0d want 4", lat); else passed++;
    checks++; if (off !== 1'b0 || rom_req !== 1'b0) $display("FAIL def_release: en %b req %b want 0/0", off, rom_req); else passed++;
  endtask

  task automatic test_slot2();
    logic wr; logic [21:0] ra; logic [7:0] d; logic en, off; int lat;
    bus_write(16'hFFFF, 8'h05);
    do_read(16'h8123, 8'h11, 1, wr, ra, d, en, lat, off);
    checks++; if (ra !== 22'h014123 || d !== 8'h11) $display("FAIL slot2: got %h/%h want 014123/11", ra, d); else passed++;
    bus_write(16'hFFFD, 8'h07);
    do_read(16'h0100, 8'h22, 0, wr, ra, d, en, lat, off);
    checks++; if (ra !== 22'h000100) $display("FAIL fixed_1k: got %h want 000100", ra); else passed++;
    do_read(16'h0400, 8'h33, 0, wr, ra, d, en, lat, off);
    checks++; if (ra !== 22'h01C400) $display("FAIL slot0: got %h want 01c400", ra); else passed++;
  endtask

  task automatic test_cart_ram();
    logic wr; logic [21:0] ra; logic [7:0] d; logic en, off; int lat;
    bus_write(16'hFFFC, 8'h08);
    cart_address = 16'h8010; cart_data_wr = 8'hA5; cart_cs = 1'b1; cart_wr = 1'b1;
    sram_m[15'h0010] = 8'hA5;
    step();
    checks++; if (sram_we !== 1'b1 || sram_addr !== 15'h0010 || sram_d !== 8'hA5)
      $display("FAIL ram_write: we %b addr %h d %h want 1/0010/a5", sram_we, sram_addr, sram_d); else passed++;
    step();
    checks++; if (sram_we !== 1'b0) $display("FAIL ram_we_pulse: got %b want 0", sram_we); else passed++;
    cart_wr = 1'b0; cart_cs = 1'b0;
    step();
    bus_write(16'hFFFC, 8'h0C);
    bus_write(16'h8010, 8'h3C);
    do_read(16'h8010, 8'hEE, 0, wr, ra, d, en, lat, off);
    checks++; if (wr !== 1'b0) $display("FAIL ram_no_req: got %b want 0", wr); else passed++;
    checks++; if (sram_addr !== 15'h4010) $display("FAIL ram_page: got %h want 4010", sram_addr); else passed++;
    checks++; if (d !== 8'h3C || en !== 1'b1 || lat !== 3)
      $display("FAIL ram_read1: data %h en %b lat %0d want 3c/1/3", d, en, lat); else passed++;
    bus_write(16'hFFFC, 8'h08);
    do_read(16'h8010, 8'hEE, 0, wr, ra, d, en, lat, off);
    checks++; if (d !== sram_m[15'h0010] || off !== 1'b0)
      $display("FAIL ram_read0: data %h off %b want %h/0", d, off, sram_m[15'h0010]); else passed++;
    bus_write(16'hFFFC, 8'h00);
  endtask

  task automatic test_mask();
    logic wr; logic [21:0] ra; logic [7:0] d; logic en, off; int lat;
    mask_m = 8'h0F; rom_bank_mask = mask_m;
    bus_write(16'hFFFE, 8'h13);
    do_read(16'h4000, 8'h44, 1, wr, ra, d, en, lat, off);
    checks++; if (ra !== 22'h00C000) $display("FAIL mask: got %h want 00c000", ra); else passed++;
    mask_m = 8'hFF; rom_bank_mask = mask_m;
  endtask

  task automatic test_abort();
    logic wr; logic [21:0] ra; logic [7:0] d; logic en, off; int lat;
    logic seen_en;
    cart_address = 16'h4000; cart_cs = 1'b1; cart_oe = 1'b1;
    step();
    checks++; if (rom_req !== 1'b1) $display("FAIL abort_req: got %b want 1", rom_req); else passed++;
    cart_oe = 1'b0;
    step(); step();
    checks++; if (rom_req !== 1'b1) $display("FAIL abort_req_held: got %b want 1", rom_req); else passed++;
    rom_ack = 1'b1; rom_q = 8'h77;
    step();
    rom_ack = 1'b0; cart_cs = 1'b0;
    seen_en = cart_data_en;
    step(); seen_en |= cart_data_en;
    step(); seen_en |= cart_data_en;
    checks++; if (seen_en !== 1'b0 || rom_req !== 1'b0) $display("FAIL abort_en: en %b req %b want 0/0", seen_en, rom_req); else passed++;
    do_read(16'h4000, 8'h99, 1, wr, ra, d, en, lat, off);
    checks++; if (ra !== model_rom(16'h4000) || d !== 8'h99 || lat !== 3)
      $display("FAIL abort_next: addr %h data %h lat %0d want %h/99/3", ra, d, lat, model_rom(16'h4000)); else passed++;
  endtask

  task automatic test_reg_during_fetch();
    logic [21:0] exp_a;
    exp_a = model_rom(16'h4000);
    cart_address = 16'h4000; cart_cs = 1'b1; cart_oe = 1'b1;
    step();
    cart_address = 16'hFFFE; cart_data_wr = 8'h2A; cart_wr = 1'b1;
    bank_m[1] = 8'h2A;
    step(); step();
    checks++; if (rom_addr !== exp_a) $display("FAIL fetch_addr_stable: got %h want %h", rom_addr, exp_a); else passed++;
    cart_wr = 1'b0; rom_ack = 1'b1; rom_q = 8'hC3;
    step();
    rom_ack = 1'b0;
    checks++; if (cart_data !== 8'hC3 || cart_data_en !== 1'b1)
      $display("FAIL fetch_wr_data: got %h/%b want c3/1", cart_data, cart_data_en); else passed++;
    cart_oe = 1'b0; cart_cs = 1'b0;
    step(); step();
  endtask

  task automatic test_back_to_back();
    logic wr; logic [21:0] ra; logic [7:0] d; logic en, off; int lat;
    do_read(16'h7FFF, 8'h01, 0, wr, ra, d, en, lat, off);
    checks++; if (ra !== model_rom(16'h7FFF) || d !== 8'h01) $display("FAIL b2b_first: got %h/%h want %h/01", ra, d, model_rom(16'h7FFF)); else passed++;
    do_read(16'h03FF, 8'h02, 3, wr, ra, d, en, lat, off);
    checks++; if (ra !== 22'h0003FF || d !== 8'h02 || lat !== 5) $display("FAIL b2b_second: got %h/%h lat %0d want 0003ff/02/5", ra, d, lat); else passed++;
  endtask

  task automatic test_reset_midfetch();
    logic wr; logic [21:0] ra; logic [7:0] d; logic en, off; int lat;
    cart_address = 16'h8123; cart_cs = 1'b1; cart_oe = 1'b1;
    step();
    checks++; if (rom_req !== 1'b1) $display("FAIL rst_fetch_req: got %b want 1", rom_req); else passed++;
    ext_reset = 1'b1; cart_cs = 1'b0; cart_oe = 1'b0;
    step();
    checks++; if (rom_req !== 1'b0) $display("FAIL rst_drop_req: got %b want 0", rom_req); else passed++;
    ext_reset = 1'b0; model_reset();
    rom_ack = 1'b1; rom_q = 8'hEE;
    step();
    rom_ack = 1'b0;
    step();
    checks++; if (cart_data_en !== 1'b0 || cart_data !== 8'h00) $display("FAIL rst_stray_ack: en %b data %h want 0/00", cart_data_en, cart_data); else passed++;
    do_read(16'h8123, 8'h61, 1, wr, ra, d, en, lat, off);
    checks++; if (ra !== 22'h008123 || d !== 8'h61) $display("FAIL rst_bank2: got %h/%h want 008123/61", ra, d); else passed++;
    do_read(16'h4123, 8'h62, 0, wr, ra, d, en, lat, off);
    checks++; if (ra !== 22'h004123) $display("FAIL rst_bank1: got %h want 004123", ra); else passed++;
  endtask

  task automatic test_random();
    logic wr; logic [21:0] ra; logic [7:0] d, q, wd; logic en, off; int lat, dly;
    logic [15:0] a;
    logic [7:0] masks [3];
    masks[0] = 8'h0F; masks[1] = 8'h3F; masks[2] = 8'hFF;
    for (int i = 0; i < 30; i++) begin
      bus_write(16'hFFFC + 16'($urandom_range(0, 3)), 8'($urandom));
      mask_m = masks[$urandom_range(0, 2)];
      rom_bank_mask = mask_m;
      a = 16'($urandom_range(0, 16'hBFFF));
      q = 8'($urandom);
      dly = $urandom_range(0, 3);
      if (model_is_sram(a)) begin
        wd = 8'($urandom);
        bus_write(a, wd);
        do_read(a, q, dly, wr, ra, d, en, lat, off);
        checks++;
        if (wr !== 1'b0 || d !== wd || en !== 1'b1 || lat !== 3 || off !== 1'b0)
          $display("FAIL rand_ram[%0d] a=%h: req %b data %h en %b lat %0d off %b want 0/%h/1/3/0", i, a, wr, d, en, lat, off, wd);
        else passed++;
      end else begin
        do_read(a, q, dly, wr, ra, d, en, lat, off);
        checks++;
        if (wr !== 1'b1 || ra !== model_rom(a) || d !== q || en !== 1'b1 || lat !== dly + 2 || off !== 1'b0)
          $display("FAIL rand_rom[%0d] a=%h: addr %h data %h en %b lat %0d off %b want %h/%h/1/%0d/0", i, a, ra, d, en, lat, off, model_rom(a), q, dly + 2);
        else passed++;
      end
    end
  endtask

  initial begin
    ext_reset = 1'b1; cart_address = 16'h0000; cart_cs = 0; cart_oe = 0; cart_wr = 0;
    cart_data_wr = 8'h00; rom_ack = 0; rom_q = 8'h00;
    mask_m = 8'hFF; rom_bank_mask = mask_m;
    model_reset();
    test_reset();
    test_default_banks();
    test_slot2();
    test_cart_ram();
    test_mask();
    test_abort();
    test_reg_during_fetch();
    test_back_to_back();
    test_reset_midfetch();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sms_cart_mapper.md
Name: sms_cart_mapper

Overview:
- Cartridge-side responder for the SMS cartridge bus driven by the board: decodes Z80 cart cycles, implements the Sega 315-5235 style paging mapper (registers at FFFC–FFFF) and on-cart battery RAM.
- Fetches ROM bytes from an external ROM store (SDRAM/BRAM) through a req/ack handshake.
- Returns read data on cart_data / cart_data_en.

Parameters:
ROM_AW, 22, ROM store byte-address width; bank number width is ROM_AW-14.
SRAM_AW, 15, cart RAM address width (2 × 16 KB pages).

Ports:
MCLK  in  1  system clock
ext_reset  in  1  synchronous, active-high reset
cart_address  in  16  Z80 address
cart_cs  in  1  cart select, active-high (0000–BFFF cycles)
cart_oe  in  1  read strobe, active-high
cart_wr  in  1  write strobe, active-high
cart_data_wr  in  8  write data
cart_data  out  8  read data to board
cart_data_en  out  1  cart_data valid; board samples it every MCLK
rom_bank_mask  in  ROM_AW-14  bank mask (ROM size − 1 in banks)
rom_addr  out  ROM_AW  ROM byte address
rom_req  out  1  fetch request, held until ack
rom_ack  in  1  single-cycle pulse; rom_q valid in the same cycle
rom_q  in  8  ROM data
sram_addr  out  SRAM_AW  cart RAM address
sram_d  out  8  cart RAM write data
sram_we  out  1  one-cycle write strobe
sram_q  in  8  cart RAM data, 1-cycle synchronous read latency

Behaviour:
- Clock, reset and polarity: one clock, MCLK; reset is ext_reset, synchronous and active-high.
- Reset values: ctrl=0x00, bank0=0, bank1=1, bank2=2; cart_data=0; cart_data_en=0; rom_req=0; sram_we=0; state=IDLE.
- Reset asserted mid-fetch drops rom_req immediately. A late rom_ack after reset is ignored.
- Strobe edges: cart_wr, cart_oe and cart_cs are registered each MCLK (1-cycle delayed copies).
  - Write event = rising edge of (cart_wr).
  - Read event = rising edge of (cart_cs & cart_oe).
- Register writes are snooped on address only, independent of cart_cs. A write event at:
  - FFFC → ctrl[7:0]
  - FFFD → bank0
  - FFFE → bank1
  - FFFF → bank2
  - Bank values are truncated to ROM_AW-14 bits. Takes effect the next MCLK.
- Address map (bank = reg & rom_bank_mask; rom_addr = {bank, A[13:0]}):
  - 0000–03FF: bank 0, fixed.
  - 0400–3FFF: bank0.
  - 4000–7FFF: bank1.
  - 8000–BFFF: if ctrl[3]=1 → cart RAM, sram_addr = {ctrl[2], A[13:0]}; else bank2.
  - ctrl[1:0] (bank shift) and ctrl[4] are stored but ignored.
- Cart RAM write: write event with cart_cs, A in 8000–BFFF and ctrl[3]=1 → sram_we=1 for exactly one MCLK, sram_d=cart_data_wr. Writes to ROM regions are ignored, apart from the register snoop.
- Read FSM states: IDLE, FETCH, SRAMRD, HOLD.
  - IDLE → FETCH on a read event to a ROM region. rom_addr is latched; rom_req=1.
  - IDLE → SRAMRD on a read event to cart RAM. sram_addr is latched.
  - FETCH: rom_req held until rom_ack; rom_req drops in the cycle after ack. On ack, cart_data←rom_q, then:
    - HOLD if cart_cs&cart_oe is still high;
    - IDLE otherwise (result discarded).
  - SRAMRD: one wait cycle, then cart_data←sram_q, then HOLD, or IDLE if the strobe has dropped.
  - HOLD: cart_data_en=1 while cart_cs&cart_oe. On deassertion, cart_data_en=0 in the same registered cycle and the FSM returns to IDLE.
- cart_data_en is 0 in all other states.
- Latency: ROM read event → cart_data_en = ack latency + 1 MCLK; cart RAM read = 3 MCLK.
- A read event during FETCH/SRAMRD cannot occur (strobe still high). A new event after abort is accepted only from IDLE.
- rom_addr and sram_addr are stable while a request is outstanding.
- A register write concurrent with a read does not alter an in-flight fetch address.

Decomposition:
- Shared package sms_cart_pkg holds:
  - constants for the register addresses FFFC–FFFF;
  - region boundaries 0400, 4000, 8000, C000;
  - ctrl bit indices (RAM_EN=3, RAM_PAGE=2);
  - an enum for the read FSM states.
- One natural sub-module: sms_cart_decode (combinational address → {region, rom_addr, sram_addr}). The FSM and registers stay in the top.

Test Plan:
- Default banks: reset, read 0x4123 → rom_addr=0x04123, rom_req until ack. Ack with rom_q=0x5A → cart_data=0x5A, cart_data_en=1 until oe drops.
- Slot 2: write 0x05 to FFFF, then read 0x8123 → rom_addr=0x14123. Write FFFD=0x07, read 0x0100 → rom_addr=0x00100; read 0x0400 → 0x1C400.
- Cart RAM: write FFFC=0x08, write 0xA5 to 0x8010 → one-cycle sram_we, sram_addr=0x0010, sram_d=0xA5. FFFC=0x0C, read 0x8010 → sram_addr=0x4010, no rom_req, cart_data_en after 3 MCLK.
- Mask: rom_bank_mask=0x0F, FFFE=0x13, read 0x4000 → rom_addr=0x0C000.
- Abort: read 0x4000, drop cart_oe before ack, ack later → cart_data_en never asserts, FSM IDLE, next read proceeds normally.
- Reset mid-fetch: assert ext_reset during FETCH → rom_req=0 next cycle, banks back to 0/1/2, stray ack ignored.
